// File: rtl/AHBCommon_pkg.sv
// Shared AHB encodings and the command manager FSM state type.
package AHBCommon_pkg;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      MGR_RUN,
      MGR_ERR_WAIT,
      MGR_CANCEL
   } ManagerState;

endpackage

// File: rtl/ahb_cmd_manager.sv
// Valid/ready command stream to single NONSEQ AHB transfers, one in-order
// response per command; handles wait states and two-cycle ERROR with cancel.
module ahb_cmd_manager
   import AHBCommon_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmdValid,
   output logic                 cmdReady,
   input  logic                 cmdWrite,
   input  logic [AddrWidth-1:0] cmdAddr,
   input  logic [DataWidth-1:0] cmdWData,
   output logic                 rspValid,
   output logic [DataWidth-1:0] rspData,
   output logic                 rspError,
   output logic                 rspCancel,
   output logic [AddrWidth-1:0] addr,
   output logic                 write,
   output logic [1:0]           trans,
   output logic [DataWidth-1:0] wData,
   input  logic [DataWidth-1:0] rData,
   input  logic                 ready,
   input  logic                 resp
);

   ManagerState          state_q, state_d;
   logic                 a_valid_q, a_valid_d;
   logic                 a_write_q, a_write_d;
   logic [AddrWidth-1:0] a_addr_q, a_addr_d;
   logic [DataWidth-1:0] a_wdata_q, a_wdata_d;
   logic                 d_valid_q, d_valid_d;
   logic                 d_write_q, d_write_d;
   logic [DataWidth-1:0] d_wdata_q, d_wdata_d;
   logic                 cancel_pending_q, cancel_pending_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 rsp_cancel_q, rsp_cancel_d;
   logic                 cmd_accept;

   assign cmdReady   = !reset && (state_q == MGR_RUN) && ready && (resp != RESP_ERROR);
   assign cmd_accept = cmdValid && cmdReady;

   always_comb begin
      state_d          = state_q;
      a_valid_d        = a_valid_q;
      a_write_d        = a_write_q;
      a_addr_d         = a_addr_q;
      a_wdata_d        = a_wdata_q;
      d_valid_d        = d_valid_q;
      d_write_d        = d_write_q;
      d_wdata_d        = d_wdata_q;
      cancel_pending_d = cancel_pending_q;
      rsp_valid_d      = 1'b0;
      rsp_data_d       = '0;
      rsp_error_d      = 1'b0;
      rsp_cancel_d     = 1'b0;

      unique case (state_q)
         MGR_RUN: begin
            if (ready) begin
               // ready with ERROR here is a protocol violation: retire as an error completion
               if (d_valid_q) begin
                  rsp_valid_d = 1'b1;
                  if (resp == RESP_ERROR) begin
                     rsp_error_d = 1'b1;
                  end else if (!d_write_q) begin
                     rsp_data_d = rData;
                  end
               end
               d_valid_d = a_valid_q;
               d_write_d = a_write_q;
               d_wdata_d = a_wdata_q;
               a_valid_d = cmd_accept;
               if (cmd_accept) begin
                  a_write_d = cmdWrite;
                  a_addr_d  = cmdAddr;
                  a_wdata_d = cmdWData;
               end
            end else if (resp == RESP_ERROR) begin
               // Drop the pipelined address phase; it is reported as cancelled later.
               a_valid_d        = 1'b0;
               cancel_pending_d = a_valid_q;
               state_d          = MGR_ERR_WAIT;
            end
         end
         MGR_ERR_WAIT: begin
            if (ready) begin
               rsp_valid_d = d_valid_q;
               rsp_error_d = d_valid_q;
               d_valid_d   = 1'b0;
               state_d     = cancel_pending_q ? MGR_CANCEL : MGR_RUN;
            end
         end
         MGR_CANCEL: begin
            rsp_valid_d      = 1'b1;
            rsp_cancel_d     = 1'b1;
            cancel_pending_d = 1'b0;
            state_d          = MGR_RUN;
         end
         default: state_d = MGR_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= MGR_RUN;
         a_valid_q        <= 1'b0;
         a_write_q        <= 1'b0;
         a_addr_q         <= '0;
         a_wdata_q        <= '0;
         d_valid_q        <= 1'b0;
         d_write_q        <= 1'b0;
         d_wdata_q        <= '0;
         cancel_pending_q <= 1'b0;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= '0;
         rsp_error_q      <= 1'b0;
         rsp_cancel_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         a_valid_q        <= a_valid_d;
         a_write_q        <= a_write_d;
         a_addr_q         <= a_addr_d;
         a_wdata_q        <= a_wdata_d;
         d_valid_q        <= d_valid_d;
         d_write_q        <= d_write_d;
         d_wdata_q        <= d_wdata_d;
         cancel_pending_q <= cancel_pending_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_data_q       <= rsp_data_d;
         rsp_error_q      <= rsp_error_d;
         rsp_cancel_q     <= rsp_cancel_d;
      end
   end

   assign trans     = a_valid_q ? TRANS_NONSEQ : TRANS_IDLE;
   assign addr      = a_addr_q;
   assign write     = a_write_q;
   assign wData     = d_wdata_q;
   assign rspValid  = rsp_valid_q;
   assign rspData   = rsp_data_q;
   assign rspError  = rsp_error_q;
   assign rspCancel = rsp_cancel_q;

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Directed bench for ahb_cmd_manager: hand-computed cycle-by-cycle expectations.
module tb_ahb_cmd_manager;
   import AHBCommon_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmdValid, cmdReady, cmdWrite;
   logic [31:0] cmdAddr, cmdWData;
   logic        rspValid, rspError, rspCancel;
   logic [31:0] rspData;
   logic [31:0] addr, wData, rData;
   logic        write, ready, resp;
   logic [1:0]  trans;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   ahb_cmd_manager #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk(clk), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
      .cmdAddr(cmdAddr), .cmdWData(cmdWData),
      .rspValid(rspValid), .rspData(rspData), .rspError(rspError), .rspCancel(rspCancel),
      .addr(addr), .write(write), .trans(trans), .wData(wData),
      .rData(rData), .ready(ready), .resp(resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      cmdValid = v; cmdWrite = w; cmdAddr = a; cmdWData = d;
   endtask

   task automatic bus(input logic rdy, input logic rs, input logic [31:0] rd);
      ready = rdy; resp = rs; rData = rd;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                          input logic e, input logic c);
      chk({tag, ".rspValid"}, {31'b0, rspValid}, {31'b0, v});
      chk({tag, ".rspData"}, rspData, d);
      chk({tag, ".rspError"}, {31'b0, rspError}, {31'b0, e});
      chk({tag, ".rspCancel"}, {31'b0, rspCancel}, {31'b0, c});
   endtask

   initial begin
      reset = 1'b1;
      cmd(1'b0, 1'b0, 32'h0, 32'h0);
      bus(1'b1, RESP_OKAY, 32'h0);
      next_cycle();
      next_cycle();
      #1;
      chk("rst.trans", {30'b0, trans}, 32'h0);
      chk("rst.addr", addr, 32'h0);
      chk("rst.write", {31'b0, write}, 32'h0);
      chk("rst.wData", wData, 32'h0);
      chk("rst.cmdReady", {31'b0, cmdReady}, 32'h0);
      chk_rsp("rst", 1'b0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;

      // Test 1: write then read same address, always ready
      next_cycle();
      cmd(1'b1, 1'b1, 32'h4, 32'hA5A5_0001); #1;
      chk("t1c0.cmdReady", {31'b0, cmdReady}, 32'h1);
      next_cycle();
      cmd(1'b1, 1'b0, 32'h4, 32'h0); #1;
      chk("t1c1.trans", {30'b0, trans}, {30'b0, TRANS_NONSEQ});
      chk("t1c1.addr", addr, 32'h4);
      chk("t1c1.write", {31'b0, write}, 32'h1);
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
      chk("t1c2.trans", {30'b0, trans}, {30'b0, TRANS_NONSEQ});
      chk("t1c2.write", {31'b0, write}, 32'h0);
      chk("t1c2.wData", wData, 32'hA5A5_0001);
      chk_rsp("t1c2", 1'b0, 32'h0, 1'b0, 1'b0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'hA5A5_0001); #1;
      chk("t1c3.trans", {30'b0, trans}, {30'b0, TRANS_IDLE});
      chk_rsp("t1c3", 1'b1, 32'h0, 1'b0, 1'b0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk_rsp("t1c4", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
      next_cycle(); #1;
      chk("t1c5.rspValid", {31'b0, rspValid}, 32'h0);

      // Test 2: back-to-back reads, two wait states on the first
      cmd(1'b1, 1'b0, 32'h10, 32'h0); #1;
      next_cycle();
      cmd(1'b1, 1'b0, 32'h20, 32'h0); #1;
      chk("t2c1.addr", addr, 32'h10);
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0);
      bus(1'b0, RESP_OKAY, 32'h0); #1;
      chk("t2c2.addr", addr, 32'h20);
      chk("t2c2.cmdReady", {31'b0, cmdReady}, 32'h0);
      next_cycle(); #1;
      chk("t2c3.addr", addr, 32'h20);
      chk("t2c3.trans", {30'b0, trans}, {30'b0, TRANS_NONSEQ});
      chk("t2c3.rspValid", {31'b0, rspValid}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h1111); #1;
      chk("t2c4.addr", addr, 32'h20);
      chk("t2c4.rspValid", {31'b0, rspValid}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h2222); #1;
      chk("t2c5.trans", {30'b0, trans}, {30'b0, TRANS_IDLE});
      chk_rsp("t2c5", 1'b1, 32'h1111, 1'b0, 1'b0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk_rsp("t2c6", 1'b1, 32'h2222, 1'b0, 1'b0);
      next_cycle();

      // Test 3: read ERROR with a pipelined write cancelled
      cmd(1'b1, 1'b0, 32'h30, 32'h0); #1;
      next_cycle();
      cmd(1'b1, 1'b1, 32'h34, 32'hBEEF); #1;
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0);
      bus(1'b0, RESP_ERROR, 32'h0); #1;
      chk("t3e0.trans", {30'b0, trans}, {30'b0, TRANS_NONSEQ});
      chk("t3e0.cmdReady", {31'b0, cmdReady}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_ERROR, 32'hDEAD); #1;
      chk("t3e1.trans", {30'b0, trans}, {30'b0, TRANS_IDLE});
      chk("t3e1.cmdReady", {31'b0, cmdReady}, 32'h0);
      chk("t3e1.rspValid", {31'b0, rspValid}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk_rsp("t3e2", 1'b1, 32'h0, 1'b1, 1'b0);
      chk("t3e2.cmdReady", {31'b0, cmdReady}, 32'h0);
      next_cycle(); #1;
      chk_rsp("t3e3", 1'b1, 32'h0, 1'b0, 1'b1);
      chk("t3e3.cmdReady", {31'b0, cmdReady}, 32'h1);
      next_cycle(); #1;
      chk("t3e4.rspValid", {31'b0, rspValid}, 32'h0);

      // Test 4: single write ERROR, no follow-on
      cmd(1'b1, 1'b1, 32'h40, 32'h5555); #1;
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
      next_cycle();
      bus(1'b0, RESP_ERROR, 32'h0); #1;
      chk("t4e0.wData", wData, 32'h5555);
      chk("t4e0.trans", {30'b0, trans}, {30'b0, TRANS_IDLE});
      next_cycle();
      bus(1'b1, RESP_ERROR, 32'h0); #1;
      chk("t4e1.rspValid", {31'b0, rspValid}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk_rsp("t4e2", 1'b1, 32'h0, 1'b1, 1'b0);
      chk("t4e2.state", {30'b0, dut.state_q}, {30'b0, MGR_RUN});
      chk("t4e2.cmdReady", {31'b0, cmdReady}, 32'h1);
      next_cycle(); #1;
      chk("t4e3.rspValid", {31'b0, rspValid}, 32'h0);

      // Test 5: reset during wait state with two commands in flight
      cmd(1'b1, 1'b0, 32'h50, 32'h0); #1;
      next_cycle();
      cmd(1'b1, 1'b1, 32'h54, 32'h77); #1;
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0);
      bus(1'b0, RESP_OKAY, 32'h0); #1;
      chk("t5c2.wData", wData, 32'h0);
      chk("t5c2.addr", addr, 32'h54);
      next_cycle();
      reset = 1'b1; #1;
      chk("t5c3.cmdReady", {31'b0, cmdReady}, 32'h0);
      next_cycle();
      reset = 1'b0;
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk("t5r.trans", {30'b0, trans}, {30'b0, TRANS_IDLE});
      chk("t5r.addr", addr, 32'h0);
      chk("t5r.write", {31'b0, write}, 32'h0);
      chk("t5r.wData", wData, 32'h0);
      chk_rsp("t5r", 1'b0, 32'h0, 1'b0, 1'b0);
      next_cycle();
      cmd(1'b1, 1'b0, 32'h60, 32'h0); #1;
      chk("t5n0.rspValid", {31'b0, rspValid}, 32'h0);
      chk("t5n0.cmdReady", {31'b0, cmdReady}, 32'h1);
      next_cycle();
      cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
      chk("t5n1.addr", addr, 32'h60);
      chk("t5n1.trans", {30'b0, trans}, {30'b0, TRANS_NONSEQ});
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'hCAFE); #1;
      chk("t5n2.rspValid", {31'b0, rspValid}, 32'h0);
      next_cycle();
      bus(1'b1, RESP_OKAY, 32'h0); #1;
      chk_rsp("t5n3", 1'b1, 32'hCAFE, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_cmd_manager.md
# ahb_cmd_manager

AHB manager that turns a simple valid/ready command stream into single NONSEQ AHB transfers and returns one in-order response per command. Sits between a local requester (test driver, DMA, or CPU load/store unit) and the AHB fabric, driving the manager side of the bus that subordinate devices respond to. Address and data phases are pipelined, wait states are honoured, and the two-cycle ERROR response is handled, including cancellation of the pipelined follow-on transfer.

## Interface
- AddrWidth, 32, address bus width
- DataWidth, 32, data bus width
- clk  in  1  bus clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted this cycle when cmdValid && cmdReady
- cmdWrite  in  1  1 = write, 0 = read
- cmdAddr  in  AddrWidth  transfer address
- cmdWData  in  DataWidth  write data
- rspValid  out  1  one-cycle response pulse; no backpressure
- rspData  out  DataWidth  read data (0 for writes and errors)
- rspError  out  1  subordinate returned ERROR
- rspCancel  out  1  command was cancelled, never completed on the bus
- addr  out  AddrWidth  AHB address phase address
- write  out  1  AHB address phase direction
- trans  out  2  AHB transfer type (TRANS_IDLE / TRANS_NONSEQ only)
- wData  out  DataWidth  AHB data phase write data
- rData  in  DataWidth  AHB read data
- ready  in  1  AHB transfer-done/ready from the selected subordinate
- resp  in  1  AHB response (RESP_OKAY / RESP_ERROR)

## Operation
- Two stage registers: address stage (aValid, aWrite, aAddr, aWData) drives addr/write/trans; data stage (dValid, dWrite, dWData) drives wData.
- trans = TRANS_NONSEQ when aValid, else TRANS_IDLE. BUSY and SEQ are never issued.
- FSM states (ManagerState): MGR_RUN, MGR_ERR_WAIT, MGR_CANCEL.
- MGR_RUN, ready=1, resp=OKAY: data stage retires (if dValid: rspValid=1 next cycle, rspData=rData for reads, 0 for writes); address stage advances to data stage; accepted command loads address stage, else aValid<=0.
- MGR_RUN, ready=0, resp=OKAY: wait state, all stage registers hold, cmdReady=0.
- MGR_RUN, ready=0, resp=ERROR (first error cycle): clear aValid (trans=IDLE in next cycle), record cancelPending=aValid, go MGR_ERR_WAIT.
- MGR_ERR_WAIT, ready=1, resp=ERROR: retire data stage with rspError=1; go MGR_CANCEL if cancelPending, else MGR_RUN.
- MGR_CANCEL: emit rspValid with rspCancel=1 for the cancelled command; go MGR_RUN.
- cmdReady = !reset && state==MGR_RUN && ready && !(resp==RESP_ERROR). Combinational from ready/resp.
- Responses always in command order; error response precedes the cancel response.
- Reset values: trans=TRANS_IDLE, addr=0, write=0, wData=0, rspValid=0, rspData=0, rspError=0, rspCancel=0, aValid=dValid=0, state=MGR_RUN.
- Reset mid-transfer: in-flight commands are dropped without a response.

## Timing
- Command accepted at edge N: NONSEQ on bus in cycle N+1; with no wait states, data phase in N+2; rspValid in N+3. Minimum latency 3 cycles; throughput 1 command/cycle.
- Each wait cycle (ready=0) adds one cycle to every in-flight command's latency.
- Error: first error cycle E, trans=IDLE in E+1, error rspValid in E+2, cancel rspValid (if any) in E+3. First new cmdReady is in E+2 (no cancel) or E+3 (cancel).
- ready=1 with resp=ERROR outside MGR_ERR_WAIT is a protocol violation; it is treated as an error completion of the data stage.

## Structure
- AHBCommon_pkg: existing TRANS_* and RESP_* constants; add enum ManagerState {MGR_RUN, MGR_ERR_WAIT, MGR_CANCEL}.
- Single module, no sub-modules; stage registers and FSM in one always_ff, outputs via continuous assigns.

## Test plan
- Write 0xA5A5_0001 to 0x4 then read 0x4, with the subordinate always ready: NONSEQ on consecutive cycles. Expected: rspValid at cmd+3 and cmd+4, and the read rspData=0xA5A5_0001.
- Back-to-back reads with 2 wait cycles on the first: the second address is held on the bus for 2 extra cycles. Expected: both responses in order, each delayed 2 cycles.
- Read with ERROR response while a second command is pipelined: trans=IDLE in the cycle after the first error cycle. Expected: rspError=1, then rspCancel=1 on the next cycle.
- Single write with ERROR and no follow-on command: exactly one response with rspError=1, and state returns to MGR_RUN.
- Assert reset mid-wait-state with 2 commands in flight: all outputs at reset values next cycle and no rspValid. Expected: a new command completes normally after reset is released.
